instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Small program sequencer that drives the 5-bit control word into the TPU control decoder, replacing host cycle-by-cycle instruction driving. The host writes a short program of {hold count, instruction} entries into an internal register file, then pulses `start`. The block issues each instruction for `count+1` cycles in order and reports completion with a one-cycle `done` pulse. It sits between the host/test harness and the control decoder; its `instruction` output feeds the decoder's `instruction` input directly.

## Interface
- `DEPTH`, 16: number of program entries (power of two, ≥2); `AW = $clog2(DEPTH)`.
- `CNT_W`, 8: width of the per-entry hold count.
- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `prog_we`  input  1  program write strobe.
- `prog_addr`  input  AW  program entry address.
- `prog_data`  input  CNT_W+5  entry: [CNT_W+4:5] hold count, [4:0] instruction.
- `prog_len`  input  AW+1  number of entries to run; sampled at `start`; values >DEPTH clamp to DEPTH.
- `start`  input  1  begin program (level, sampled in IDLE only).
- `abort`  input  1  synchronous stop of a running program.
- `stop`  input  1  loop exit request (used only with `SEQ_LOOP_EN`).
- `instruction`  output  5  registered control word to decoder; 5'b0 = NOP.
- `pc`  output  AW  index of entry currently issued.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- Program memory: DEPTH × (CNT_W+5) flops, cleared to 0 by `rst`. Writes accepted when not in RUN; `prog_we` in RUN is dropped.
- IDLE, `start`=1, len≠0: → RUN; `pc`←0, `instruction`←mem[0].instr, hold←mem[0].count, `busy`←1; latch len.
- IDLE, `start`=1, len=0: → DONE; `instruction` stays 0.
- RUN, hold≠0: hold←hold−1; outputs unchanged.
- RUN, hold=0, `pc`≠len−1: `pc`←`pc`+1; load instr/hold of next entry.
- RUN, hold=0, `pc`=len−1 (end): → DONE; `instruction`←0, `busy`←0.
- DONE: `done`=1 for this cycle; → IDLE unconditionally.
- `abort` in RUN (priority over all RUN transitions): → IDLE; `instruction`←0, `busy`←0, `pc`←0; no `done`. `abort` outside RUN ignored.
- `start` outside IDLE ignored (including DONE cycle).
- Hold counter CNT_W bits, never wraps: loaded, decremented to 0.

## Timing
- Reset values: `instruction`=0, `pc`=0, `busy`=0, `done`=0, state IDLE, hold=0, memory 0. Reset acts immediately (asynchronous), including mid-run.
- Start latency: `start` sampled at edge N → first instruction visible after edge N, with `busy`=1.
- Entry k is presented for exactly mem[k].count+1 cycles; back-to-back entries with no NOP gap.
- Total `busy` cycles = Σ(count_k+1) over k<len; `done` high the cycle after `busy` falls.
- Program write takes effect at the edge it is sampled; a write in the same cycle as an accepted `start` is visible (write then read order: mem[0] read sees new data only from next edge—entry 0 uses pre-write contents).
- Abort at edge N: `instruction`=0 after edge N.

## Configuration
- `SEQ_LOOP_EN` defined: at end condition, if `stop`=0 the sequencer wraps: `pc`←0, reload entry 0, stays in RUN, no `done`; if `stop`=1 → DONE as normal. `stop` sampled only at the end boundary.
- `SEQ_LOOP_EN` undefined: `stop` ignored; program always ends after entry len−1.

## Test plan
- Program {0x14,c=0},{0x08,c=2},{0x07,c=1}, len=3, start at edge 0 → `instruction` 0x14 ×1, 0x08 ×3, 0x07 ×2, then 0; `busy` high 6 cycles; `done` pulse in cycle 7; `pc` 0,1,1,1,2,2.
- len=0, start → no `busy`, `instruction` stays 0, `done` pulse the cycle after start.
- Same program, `abort` during second cycle of 0x08 → `instruction`=0, `busy`=0, `pc`=0 next cycle; no `done`; new `start` then runs full program.
- During RUN: `prog_we` to addr 2 with 0x1F, and `start` pulses → ignored; run output identical to first scenario; mem[2] still 0x07.
- Assert `rst` asynchronously mid 0x08 → `instruction`, `busy`, `pc` 0 before next edge; memory reads back 0.
- With `SEQ_LOOP_EN`: len=2 {0x04,c=0},{0x0C,c=0}, `stop`=0 → 0x04,0x0C,0x04,0x0C…; raise `stop` → finishes current pass, then `done`.

Source files
------------

// File: rtl/instruction_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_sequencer
//
// Small program sequencer feeding the 5-bit control word of the TPU control
// decoder. The host loads {hold count, instruction} entries into an internal
// register file, then raises `start`. Each entry is issued for count+1 cycles,
// in order, and completion is flagged by a one-cycle `done` pulse.
//
// Optional feature macro: SEQ_LOOP_EN
//   defined   : at the end of the program the sequencer wraps back to entry 0
//               unless `stop` is high at that boundary.
//   undefined : `stop` is ignored; the program always ends after entry len-1.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset (control state and memory)
//   prog_we      program write strobe (dropped while running)
//   prog_addr    program entry address
//   prog_data    entry: [CNT_W+4:5] hold count, [4:0] instruction
//   prog_len     entries to run, sampled at start, clamped to DEPTH
//   start        begin program (level, sampled in IDLE only)
//   abort        synchronous stop of a running program (no done)
//   stop         loop exit request (SEQ_LOOP_EN only)
//   instruction  registered control word, 0 = NOP
//   pc           index of the entry being issued
//   busy         high while running
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module instruction_sequencer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [CNT_W+4:0]  prog_data,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              stop,
  output logic [4:0]        instruction,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              done
);

  localparam int LEN_W = AW + 1;
  localparam int ENT_W = CNT_W + 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [CNT_W-1:0]   hold;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   last_pc;
  logic [AW-1:0]      pc_next;
  logic               at_end;

  function automatic logic [4:0] entry_instr(input logic [ENT_W-1:0] e);
    return e[4:0];
  endfunction

  function automatic logic [CNT_W-1:0] entry_count(input logic [ENT_W-1:0] e);
    return e[ENT_W-1:5];
  endfunction

  assign len_c   = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;
  assign last_pc = len_q - LEN_W'(1);
  assign at_end  = ({1'b0, pc} == last_pc);
  assign pc_next = pc + AW'(1);

`ifndef SEQ_LOOP_EN
  logic unused_stop;
  assign unused_stop = stop;
`endif

  // Program memory: writes land at the sampling edge, so an entry read on the
  // same edge as a write still returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (prog_we && (state != S_RUN)) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instruction <= '0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hold        <= '0;
      len_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q <= len_c;
            if (len_c != '0) begin
              state       <= S_RUN;
              pc          <= '0;
              instruction <= entry_instr(mem[0]);
              hold        <= entry_count(mem[0]);
              busy        <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (abort) begin
            state       <= S_IDLE;
            instruction <= '0;
            busy        <= 1'b0;
            pc          <= '0;
            hold        <= '0;
          end else if (hold != '0) begin
            hold <= hold - CNT_W'(1);
          end else if (!at_end) begin
            pc          <= pc_next;
            instruction <= entry_instr(mem[pc_next]);
            hold        <= entry_count(mem[pc_next]);
          end else begin
`ifdef SEQ_LOOP_EN
            if (!stop) begin
              pc          <= '0;
              instruction <= entry_instr(mem[0]);
              hold        <= entry_count(mem[0]);
            end else begin
              state       <= S_DONE;
              instruction <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end
`else
            state       <= S_DONE;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b1;
`endif
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
module tb_instruction_sequencer;

  localparam int DEPTH = 16;
  localparam int CNT_W = 8;
  localparam int AW    = $clog2(DEPTH);

  logic              clk;
  logic              rst;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [CNT_W+4:0]  prog_data;
  logic [AW:0]       prog_len;
  logic              start;
  logic              abort;
  logic              stop;
  logic [4:0]        instruction;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  // Expected issue sequence of the reference program
  // {0x14,c=0},{0x08,c=2},{0x07,c=1}
  logic [4:0]    exp_instr [6] = '{5'h14, 5'h08, 5'h08, 5'h08, 5'h07, 5'h07};
  logic [AW-1:0] exp_pc    [6] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};

  instruction_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_len    (prog_len),
    .start       (start),
    .abort       (abort),
    .stop        (stop),
    .instruction (instruction),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int cnt, input int ins);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = {CNT_W'(cnt), 5'(ins)};
    step();
    prog_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; abort = 1'b0; stop = 1'b0;
    #12;
    checks++;
    if ({instruction, pc, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got instr=%h pc=%0d busy=%b done=%b, want all 0",
               instruction, pc, busy, done);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({instruction, pc, busy, done} !== '0) begin
      errors++;
      $display("FAIL after_reset_idle: got instr=%h pc=%0d busy=%b done=%b, want all 0",
               instruction, pc, busy, done);
    end
  endtask

  task automatic test_basic_run();
    wr(0, 0, 5'h14);
    wr(1, 2, 5'h08);
    wr(2, 1, 5'h07);
    prog_len = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instruction !== exp_instr[i] || pc !== exp_pc[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_cycle%0d: got instr=%h pc=%0d busy=%b done=%b, want instr=%h pc=%0d busy=1 done=0",
                 i, instruction, pc, busy, done, exp_instr[i], exp_pc[i]);
      end
      step();
    end
    checks++;
    if (instruction !== 5'h00 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: got instr=%h busy=%b done=%b, want instr=00 busy=0 done=1",
               instruction, busy, done);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b, want done=0 busy=0", done, busy);
    end
  endtask

  task automatic test_zero_len();
    prog_len = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || instruction !== 5'h00 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_done: got busy=%b instr=%h done=%b, want busy=0 instr=00 done=1",
               busy, instruction, done);
    end
    step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_abort();
    prog_len = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (instruction !== 5'h08 || pc !== 4'd1) begin
      errors++;
      $display("FAIL abort_pre: got instr=%h pc=%0d, want instr=08 pc=1", instruction, pc);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (instruction !== 5'h00 || busy !== 1'b0 || pc !== 4'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: got instr=%h busy=%b pc=%0d done=%b, want 00 0 0 0",
               instruction, busy, pc, done);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done=%b busy=%b, want 0 0", done, busy);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instruction !== exp_instr[i] || pc !== exp_pc[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_rerun_cycle%0d: got instr=%h pc=%0d busy=%b, want instr=%h pc=%0d busy=1",
                 i, instruction, pc, busy, exp_instr[i], exp_pc[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_rerun_done: got done=%b busy=%b, want 1 0", done, busy);
    end
    step();
  endtask

  task automatic test_ignore_in_run();
    prog_len = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instruction !== exp_instr[i] || pc !== exp_pc[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL ignore_cycle%0d: got instr=%h pc=%0d busy=%b, want instr=%h pc=%0d busy=1",
                 i, instruction, pc, busy, exp_instr[i], exp_pc[i]);
      end
      prog_we   = (i == 1);
      prog_addr = AW'(2);
      prog_data = {CNT_W'(0), 5'h1F};
      start     = (i >= 2 && i <= 4);
      step();
    end
    prog_we = 1'b0;
    start   = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || instruction !== 5'h00) begin
      errors++;
      $display("FAIL ignore_done: got done=%b busy=%b instr=%h, want 1 0 00", done, busy, instruction);
    end
    step();
    // Re-run: entry 2 must still be 0x07 held two cycles.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (instruction !== exp_instr[i] || pc !== exp_pc[i]) begin
        errors++;
        $display("FAIL ignore_mem_kept_cycle%0d: got instr=%h pc=%0d, want instr=%h pc=%0d",
                 i, instruction, pc, exp_instr[i], exp_pc[i]);
      end
      step();
    end
    step();
  endtask

  task automatic test_len_clamp();
    int busy_cycles = 0;
    int last_pc = -1;
    bit seen_done = 0;
    prog_len = 5'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (busy) begin
        busy_cycles++;
        last_pc = int'(pc);
      end
      if (done) seen_done = 1;
      else step();
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL clamp_timeout: got no done within 40 cycles, want done");
    end
    checks++;
    if (busy_cycles != 19 || last_pc != 15) begin
      errors++;
      $display("FAIL clamp_len: got busy_cycles=%0d last_pc=%0d, want 19 15", busy_cycles, last_pc);
    end
    step();
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    logic [4:0] lexp;
    wr(0, 0, 5'h04);
    wr(1, 0, 5'h0C);
    prog_len = 2;
    stop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lexp = (i % 2 == 0) ? 5'h04 : 5'h0C;
      checks++;
      if (instruction !== lexp || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL loop_cycle%0d: got instr=%h busy=%b done=%b, want instr=%h busy=1 done=0",
                 i, instruction, busy, done, lexp);
      end
      step();
    end
    stop = 1'b1;
    checks++;
    if (instruction !== 5'h04) begin
      errors++;
      $display("FAIL loop_stop_pass0: got instr=%h, want 04", instruction);
    end
    step();
    checks++;
    if (instruction !== 5'h0C || busy !== 1'b1) begin
      errors++;
      $display("FAIL loop_stop_pass1: got instr=%h busy=%b, want 0C 1", instruction, busy);
    end
    step();
    stop = 1'b0;
    checks++;
    if (instruction !== 5'h00 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL loop_stop_done: got instr=%h busy=%b done=%b, want 00 0 1", instruction, busy, done);
    end
    step();
  endtask
`else
  task automatic test_stop_ignored();
    wr(0, 0, 5'h04);
    wr(1, 0, 5'h0C);
    prog_len = 2;
    stop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (instruction !== 5'h04 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nostop_e0: got instr=%h busy=%b, want 04 1", instruction, busy);
    end
    step();
    checks++;
    if (instruction !== 5'h0C || busy !== 1'b1) begin
      errors++;
      $display("FAIL nostop_e1: got instr=%h busy=%b, want 0C 1", instruction, busy);
    end
    step();
    checks++;
    if (instruction !== 5'h00 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL nostop_end: got instr=%h busy=%b done=%b, want 00 0 1", instruction, busy, done);
    end
    step();
  endtask
`endif

  task automatic test_async_reset();
    wr(0, 0, 5'h14);
    wr(1, 2, 5'h08);
    wr(2, 1, 5'h07);
    prog_len = 3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if (instruction !== 5'h08) begin
      errors++;
      $display("FAIL areset_pre: got instr=%h, want 08", instruction);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (instruction !== 5'h00 || busy !== 1'b0 || pc !== 4'd0) begin
      errors++;
      $display("FAIL areset_immediate: got instr=%h busy=%b pc=%0d, want 00 0 0",
               instruction, busy, pc);
    end
    #1;
    rst = 1'b0;
    step();
    // Memory was cleared: a 3-entry run issues NOP for one cycle per entry.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instruction !== 5'h00 || busy !== 1'b1 || pc !== AW'(i)) begin
        errors++;
        $display("FAIL areset_mem_cleared_cycle%0d: got instr=%h busy=%b pc=%0d, want 00 1 %0d",
                 i, instruction, busy, pc, i);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_mem_done: got done=%b busy=%b, want 1 0", done, busy);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_zero_len();
    test_abort();
    test_ignore_in_run();
    test_len_clamp();
`ifdef SEQ_LOOP_EN
    test_loop();
`else
    test_stop_ignored();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
